// File: rtl/aes_round_sequencer_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
//
// Contents:
//   seq_state_t      - sequencer FSM states {IDLE, ROUND, DONE}
//   AES_NR_128/192/256 - round counts for the three AES key sizes
//   AES_BLOCK_W      - AES state/block width in bits
//   state_busy()     - true while a block is in flight (ROUND or DONE)
//
// Optional feature macro used by the files importing this package: AES_DECRYPT_EN
package aes_pkg;

  // Sequencer states. LOAD is not a separate state: the initial AddRoundKey
  // happens on the accepting cycle of IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam int AES_NR_128  = 10;
  localparam int AES_NR_192  = 12;
  localparam int AES_NR_256  = 14;
  localparam int AES_BLOCK_W = 128;

  // A block is in flight from the cycle after it is accepted until the
  // consumer takes it.
  function automatic logic state_busy(input seq_state_t s);
    return (s == ROUND) || (s == DONE);
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Handshake / control bundle between the AES round sequencer and its
// neighbours (host front end, key expansion, round datapath, consumer).
//
// Signals:
//   i_in_valid, o_in_ready    - input block handshake
//   i_key_valid, o_key_idx    - round key request to key expansion
//   i_abort                   - synchronous abort of the current block
//   o_load, o_round_en,
//   o_mix_en                  - datapath strobes
//   o_busy                    - block in flight
//   o_out_valid, i_out_ready  - output block handshake
//   i_decrypt, o_inv          - direction select / inverse flag
//                               (present only with AES_DECRYPT_EN defined)
//
// Modports: master = environment driving the sequencer, slave = sequencer.
interface aes_round_sequencer_if #(
  parameter int IDX_W = 4
);

  logic             i_in_valid;
  logic             o_in_ready;
  logic             i_key_valid;
  logic             i_abort;
  logic             o_load;
  logic             o_round_en;
  logic             o_mix_en;
  logic [IDX_W-1:0] o_key_idx;
  logic             o_busy;
  logic             o_out_valid;
  logic             i_out_ready;
`ifdef AES_DECRYPT_EN
  logic             i_decrypt;
  logic             o_inv;
`endif

  modport master (
    output i_in_valid, i_key_valid, i_abort, i_out_ready,
`ifdef AES_DECRYPT_EN
    output i_decrypt,
    input  o_inv,
`endif
    input  o_in_ready, o_load, o_round_en, o_mix_en, o_key_idx, o_busy, o_out_valid
  );

  modport slave (
    input  i_in_valid, i_key_valid, i_abort, i_out_ready,
`ifdef AES_DECRYPT_EN
    input  i_decrypt,
    output o_inv,
`endif
    output o_in_ready, o_load, o_round_en, o_mix_en, o_key_idx, o_busy, o_out_valid
  );

endinterface

// File: rtl/aes_round_sequencer_round_counter.sv
// Round counter for the AES sequencer: counts completed rounds.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clear_i      - force count to 0 (highest priority)
//   load_i       - start a block: count <= 1 (initial AddRoundKey done)
//   inc_i        - one more round completed
//   count_o      - current round count
//   terminal_o   - count equals NUM_ROUNDS
module aes_round_counter #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] count_o,
  output logic             terminal_o
);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             terminal;

  assign terminal = (cnt_q == IDX_W'(NUM_ROUNDS));

  // Increment is ignored at the terminal count so the counter can never wrap
  // or run past NUM_ROUNDS even if a caller misbehaves.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = IDX_W'(1);
    end else if (inc_i && !terminal) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o    = cnt_q;
  assign terminal_o = terminal;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller. Accepts one block per valid/ready
// handshake, drives the shared single-round datapath one round per cycle,
// requests round keys by index and presents the finished block with an
// output valid/ready handshake.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - aes_round_sequencer_if.slave (handshakes, key request, datapath strobes)
//
// Parameters:
//   NUM_ROUNDS - rounds after the initial AddRoundKey (1..14)
//   IDX_W      - round/key index width, 2**IDX_W > NUM_ROUNDS
//
// Configuration macro: AES_DECRYPT_EN adds i_decrypt/o_inv and reverses the
// key schedule order (key index = NUM_ROUNDS - rnd).
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR_128,
  parameter int IDX_W      = 4
) (
  input logic               clk,
  input logic               rst,
  aes_round_sequencer_if.slave bus
);

  seq_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             outValid_q, outValid_d;

  logic [IDX_W-1:0] rnd;
  logic             rndTerminal;
  logic             cntClear, cntLoad, cntInc;

  logic             loadEn, roundEn, mixEn;
  logic [IDX_W-1:0] keyIdx;

`ifdef AES_DECRYPT_EN
  logic             mode_q, mode_d;
  logic             decNow;
`endif

  aes_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (IDX_W)
  ) u_round_counter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cntClear),
    .load_i     (cntLoad),
    .inc_i      (cntInc),
    .count_o    (rnd),
    .terminal_o (rndTerminal)
  );

  // Next-state and Mealy datapath strobes. Abort overrides everything except
  // reset; while reset is asserted every strobe is held low even though the
  // state register already reads IDLE.
  always_comb begin
    state_d  = state_q;
    cntClear = 1'b0;
    cntLoad  = 1'b0;
    cntInc   = 1'b0;
    loadEn   = 1'b0;
    roundEn  = 1'b0;
    mixEn    = 1'b0;
`ifdef AES_DECRYPT_EN
    mode_d   = mode_q;
`endif
    if (!rst) begin
      if (bus.i_abort) begin
        state_d  = IDLE;
        cntClear = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.i_in_valid && bus.i_key_valid) begin
              loadEn  = 1'b1;
              cntLoad = 1'b1;
              state_d = ROUND;
`ifdef AES_DECRYPT_EN
              mode_d  = bus.i_decrypt;
`endif
            end
          end
          ROUND: begin
            if (bus.i_key_valid) begin
              roundEn = 1'b1;
              mixEn   = !rndTerminal;
              if (rndTerminal) begin
                state_d = DONE;
              end else begin
                cntInc = 1'b1;
              end
            end
          end
          DONE: begin
            if (bus.i_out_ready) begin
              state_d  = IDLE;
              cntClear = 1'b1;
            end
          end
          default: begin
            state_d  = IDLE;
            cntClear = 1'b1;
          end
        endcase
      end
    end
    busy_d     = state_busy(state_d);
    outValid_d = (state_d == DONE);
  end

  // Single state register; busy and out-valid are registered alongside it so
  // they come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      outValid_q <= 1'b0;
`ifdef AES_DECRYPT_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      outValid_q <= outValid_d;
`ifdef AES_DECRYPT_EN
      mode_q     <= mode_d;
`endif
    end
  end

  // Key index. In IDLE the mode flop has not captured the new block's
  // direction yet, so the load key is selected from i_decrypt directly.
`ifdef AES_DECRYPT_EN
  assign decNow = (state_q == IDLE) ? bus.i_decrypt : mode_q;
  assign keyIdx = rst    ? '0 :
                  decNow ? (IDX_W'(NUM_ROUNDS) - rnd) : rnd;
  assign bus.o_inv = mode_q && busy_q;
`else
  assign keyIdx = rst ? '0 : rnd;
`endif

  // Ready decodes IDLE directly so it rises as soon as reset releases rather
  // than one clock later.
  assign bus.o_in_ready  = (state_q == IDLE) && !rst;
  assign bus.o_load      = loadEn;
  assign bus.o_round_en  = roundEn;
  assign bus.o_mix_en    = mixEn;
  assign bus.o_key_idx   = keyIdx;
  assign bus.o_busy      = busy_q;
  assign bus.o_out_valid = outValid_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking testbench for aes_round_sequencer (NUM_ROUNDS=10).
// Inputs are applied 1 time unit after each rising edge and outputs sampled
// 1 time unit later, well away from the next edge.
// With AES_DECRYPT_EN defined, a decrypt-order key index sequence is also checked.
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   acceptsSeen;

  always #5 clk = ~clk;

  aes_round_sequencer_if #(.IDX_W(IW)) bus ();

  aes_round_sequencer #(
    .NUM_ROUNDS (NR),
    .IDX_W      (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic k, input logic a, input logic r);
    bus.i_in_valid  = v;
    bus.i_key_valid = k;
    bus.i_abort     = a;
    bus.i_out_ready = r;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ld, input logic re, input logic me,
                             input logic [IW-1:0] idx, input logic bz, input logic ov,
                             input logic ir);
    check({tag, ".load"},     32'(bus.o_load),      32'(ld));
    check({tag, ".roundEn"},  32'(bus.o_round_en),  32'(re));
    check({tag, ".mixEn"},    32'(bus.o_mix_en),    32'(me));
    check({tag, ".keyIdx"},   32'(bus.o_key_idx),   32'(idx));
    check({tag, ".busy"},     32'(bus.o_busy),      32'(bz));
    check({tag, ".outValid"}, 32'(bus.o_out_valid), 32'(ov));
    check({tag, ".inReady"},  32'(bus.o_in_ready),  32'(ir));
  endtask

  // Rounds first..last with the key always available; state is DONE after last=NR.
  task automatic runRounds(input string tag, input int first, input int last, input logic outRdy);
    for (int r = first; r <= last; r++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, outRdy);
      checkOutput($sformatf("%s.r%0d", tag, r), 1'b0, 1'b1, (r != NR), IW'(r), 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
  endtask

  initial begin
    rst = 1'b1;
`ifdef AES_DECRYPT_EN
    bus.i_decrypt = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();

    // Reset holds every output low even with a would-be accept on the inputs.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("postReset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();

    // Single block, output held three cycles before the consumer takes it.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2.accept", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    runRounds("t2", 1, NR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t2.hold%0d", i), 1'b0, 1'b0, 1'b0, 4'(NR), 1'b1, 1'b1, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t2.take", 1'b0, 1'b0, 1'b0, 4'(NR), 1'b1, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2.idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Valid without a key: no accept.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2.noKey", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2.noKeyIdle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();

    // Key stall for two cycles at rnd=4; out_ready held high throughout.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t3.accept", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    runRounds("t3a", 1, 3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("t3.stall%0d", i), 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
      nextCycle();
    end
    runRounds("t3b", 4, NR, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t3.doneAtT13", 1'b0, 1'b0, 1'b0, 4'(NR), 1'b1, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3.idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Abort at rnd=7, abort blocking an accept in IDLE, then a clean block.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t4.accept", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    runRounds("t4a", 1, 6, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4.abort", 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4.afterAbort", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t4.abortIdle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4.stillIdle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t4.reaccept", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    runRounds("t4b", 1, NR, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t4.done", 1'b0, 1'b0, 1'b0, 4'(NR), 1'b1, 1'b1, 1'b0);
    nextCycle();

    // Reset asserted mid-ROUND at rnd=5.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t1.accept", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    runRounds("t1", 1, 4, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1.r5", 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t1.inReset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1.released", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t1.reaccept", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1.restartR1", 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    nextCycle();

    // Back-to-back blocks: accept every NR+2 cycles, three blocks delivered.
    acceptsSeen = 0;
    for (int c = 0; c < 3 * (NR + 2); c++) begin
      int m;
      m = c % (NR + 2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      if (bus.o_load === 1'b1) acceptsSeen++;
      checkOutput($sformatf("t5.c%0d", c), (m == 0), (m >= 1 && m <= NR), (m >= 1 && m < NR),
                  (m <= NR) ? IW'(m) : IW'(NR), (m != 0), (m == NR + 1), (m == 0));
      nextCycle();
    end
    check("t5.accepts", 32'(acceptsSeen), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5.idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    nextCycle();

`ifdef AES_DECRYPT_EN
    // Decrypt: key indices run NR down to 0, o_inv high while busy.
    bus.i_decrypt = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6.accept", 1'b1, 1'b0, 1'b0, 4'(NR), 1'b0, 1'b0, 1'b1);
    nextCycle();
    bus.i_decrypt = 1'b0;
    for (int r = 1; r <= NR; r++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("t6.r%0d", r), 1'b0, 1'b1, (r != NR), IW'(NR - r), 1'b1, 1'b0, 1'b0);
      check($sformatf("t6.r%0d.inv", r), 32'(bus.o_inv), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    check("t6.doneValid", 32'(bus.o_out_valid), 32'd1);
    check("t6.doneInv", 32'(bus.o_inv), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6.idleInv", 32'(bus.o_inv), 32'd0);
    check("t6.idleReady", 32'(bus.o_in_ready), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
